loop_nest_sequencer: RTL and testbench

Sequences a three-level nested loop of saturating counters (inner, mid, outer) for the MNIST datapath, e.g. kernel column, kernel row and output channel of a convolution pass. Configuration is latched on a start pulse. One index tuple is then emitted per beat under a valid/ready handshake. A done pulse marks the last accepted beat. The block sits between the layer controller, which issues start and end bounds, and the address/MAC pipeline, which consumes the index tuples.

---
 rtl/loop_nest_sequencer.sv | 147 ++++++++++++++
 tb/tb_loop_nest_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_sequencer.sv
// loop_nest_sequencer: three-level nested loop index generator.
// Emits one (inner, mid, outer) tuple per accepted beat under valid/ready,
// with first/last flags, a running beat ordinal and a done pulse after the
// final beat has been taken by the consumer.
module loop_nest_sequencer #(
    parameter int unsigned Bits = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [Bits-1:0]     inner_end_i,
    input  logic [Bits-1:0]     mid_end_i,
    input  logic [Bits-1:0]     outer_end_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [Bits-1:0]     inner_o,
    output logic [Bits-1:0]     mid_o,
    output logic [Bits-1:0]     outer_o,
    output logic                first_o,
    output logic                last_o,
    output logic [3*Bits-1:0]   beat_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [Bits-1:0]   CntZero  = '0;
    localparam logic [Bits-1:0]   CntOne   = Bits'(1);
    localparam logic [3*Bits-1:0] BeatOne  = (3*Bits)'(1);

    state_t            state;
    state_t            state_next;

    logic [Bits-1:0]   inner;
    logic [Bits-1:0]   mid;
    logic [Bits-1:0]   outer;
    logic [Bits-1:0]   inner_end;
    logic [Bits-1:0]   mid_end;
    logic [Bits-1:0]   outer_end;
    logic [3*Bits-1:0] beat;

    logic              in_run;
    logic              xfer;
    logic              inner_wrap;
    logic              mid_wrap;
    logic              at_last;
    logic              start_ok;

    // Wrap/terminal detection is purely unsigned equality against latched ends.
    assign in_run     = (state == RUN);
    assign xfer       = in_run && ready_i;
    assign inner_wrap = (inner == inner_end);
    assign mid_wrap   = (mid == mid_end);
    assign at_last    = inner_wrap && mid_wrap && (outer == outer_end);
    assign start_ok   = (state == IDLE) && start_i && !abort_i;

    // State register; reset drops straight to IDLE so outputs clear at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; abort takes priority over any other move.
    always_comb begin
        state_next = state;
        valid_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        first_o    = 1'b0;
        last_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                first_o = (inner == CntZero) && (mid == CntZero) && (outer == CntZero);
                last_o  = at_last;
                if (abort_i) begin
                    state_next = IDLE;
                end else if (xfer && at_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ends are captured only on an accepted start; counters step per transfer
    // and hold on the final beat so the tuple saturates at the last index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inner     <= '0;
            mid       <= '0;
            outer     <= '0;
            beat      <= '0;
            inner_end <= '0;
            mid_end   <= '0;
            outer_end <= '0;
        end else if (start_ok) begin
            inner     <= '0;
            mid       <= '0;
            outer     <= '0;
            beat      <= '0;
            inner_end <= inner_end_i;
            mid_end   <= mid_end_i;
            outer_end <= outer_end_i;
        end else if (xfer && !at_last) begin
            beat <= beat + BeatOne;
            if (inner_wrap) begin
                inner <= '0;
                if (mid_wrap) begin
                    mid   <= '0;
                    outer <= outer + CntOne;
                end else begin
                    mid <= mid + CntOne;
                end
            end else begin
                inner <= inner + CntOne;
            end
        end
    end

    assign inner_o = inner;
    assign mid_o   = mid;
    assign outer_o = outer;
    assign beat_o  = beat;

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Directed bench for loop_nest_sequencer; expected tuples come from a
// closed-form decomposition of the beat ordinal over the configured ends.
module tb_loop_nest_sequencer;

    localparam int Bits = 8;

    logic              clk;
    logic              rst_ni;
    logic              start;
    logic              abort;
    logic [Bits-1:0]   inner_end;
    logic [Bits-1:0]   mid_end;
    logic [Bits-1:0]   outer_end;
    logic              ready;
    logic              valid;
    logic [Bits-1:0]   inner;
    logic [Bits-1:0]   mid;
    logic [Bits-1:0]   outer;
    logic              first;
    logic              last;
    logic [3*Bits-1:0] beat;
    logic              busy;
    logic              done;

    int tests_run;
    int tests_failed;

    loop_nest_sequencer #(.Bits(Bits)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .abort_i     (abort),
        .inner_end_i (inner_end),
        .mid_end_i   (mid_end),
        .outer_end_i (outer_end),
        .ready_i     (ready),
        .valid_o     (valid),
        .inner_o     (inner),
        .mid_o       (mid),
        .outer_o     (outer),
        .first_o     (first),
        .last_o      (last),
        .beat_o      (beat),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the current beat against the ordinal b of a pass with given ends.
    task automatic expect_beat(input int b, input int ie, input int me, input int oe);
        int total;
        total = (ie + 1) * (me + 1) * (oe + 1);
        check("valid", 32'(valid), 32'd1);
        check("busy",  32'(busy),  32'd1);
        check("inner", 32'(inner), 32'(b % (ie + 1)));
        check("mid",   32'(mid),   32'((b / (ie + 1)) % (me + 1)));
        check("outer", 32'(outer), 32'(b / ((ie + 1) * (me + 1))));
        check("beat",  32'(beat),  32'(b));
        check("first", 32'(first), 32'(b == 0));
        check("last",  32'(last),  32'(b == total - 1));
    endtask

    task automatic do_start(input int ie, input int me, input int oe);
        inner_end = Bits'(ie);
        mid_end   = Bits'(me);
        outer_end = Bits'(oe);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Run from beat b0 to the end with ready high, then check done and idle.
    task automatic finish_pass(input int b0, input int ie, input int me, input int oe);
        int total;
        total = (ie + 1) * (me + 1) * (oe + 1);
        ready = 1'b1;
        for (int b = b0; b < total; b++) begin
            expect_beat(b, ie, me, oe);
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(valid), 32'd0);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy",  32'(busy), 32'd0);
        check("idle_valid", 32'(valid), 32'd0);
    endtask

    logic [6:0] pat;
    int         b;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_ni    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ready     = 1'b0;
        inner_end = '0;
        mid_end   = '0;
        outer_end = '0;
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_first", 32'(first), 32'd0);
        check("rst_last",  32'(last),  32'd0);
        check("rst_beat",  32'(beat),  32'd0);
        check("rst_inner", 32'(inner), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("idle_after_rst", 32'(busy), 32'd0);

        // 12-beat pass, ready always high
        do_start(2, 1, 1);
        finish_pass(0, 2, 1, 1);

        // single-beat pass
        do_start(0, 0, 0);
        finish_pass(0, 0, 0, 0);

        // ready toggling 1,0,0,1,1,0,1 on a 4-beat pass
        pat = 7'b1011001;
        do_start(3, 0, 0);
        b = 0;
        for (int i = 0; i < 7; i++) begin
            ready = pat[i];
            expect_beat(b, 3, 0, 0);
            tick();
            if (pat[i]) b++;
        end
        ready = 1'b0;
        check("toggle_beats", 32'(b), 32'd4);
        check("toggle_done",  32'(done), 32'd1);
        tick();
        check("toggle_idle",  32'(busy), 32'd0);

        // abort during beat 5
        do_start(2, 1, 1);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_beat(i, 2, 1, 1);
            tick();
        end
        expect_beat(5, 2, 1, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        tick();
        check("abort_nodone", 32'(done), 32'd0);
        do_start(1, 0, 0);
        finish_pass(0, 1, 0, 0);

        // abort blocks a simultaneous start in IDLE
        abort = 1'b1;
        do_start(2, 0, 0);
        abort = 1'b0;
        check("abort_blocks_start", 32'(busy), 32'd0);
        tick();
        check("abort_blocks_start2", 32'(valid), 32'd0);

        // start held through RUN with ends changed mid-pass; start ignored in DONE
        inner_end = 8'd1;
        mid_end   = 8'd1;
        outer_end = 8'd0;
        start     = 1'b1;
        ready     = 1'b1;
        tick();
        inner_end = 8'd5;
        mid_end   = 8'd5;
        outer_end = 8'd5;
        for (int i = 0; i < 4; i++) begin
            expect_beat(i, 1, 1, 0);
            tick();
        end
        check("held_done", 32'(done), 32'd1);
        inner_end = 8'd0;
        mid_end   = 8'd0;
        outer_end = 8'd0;
        tick();
        check("held_idle_busy",  32'(busy),  32'd0);
        check("held_idle_valid", 32'(valid), 32'd0);
        tick();
        start = 1'b0;
        expect_beat(0, 0, 0, 0);
        tick();
        check("held_restart_done", 32'(done), 32'd1);
        tick();

        // asynchronous reset mid-pass
        do_start(2, 1, 1);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_beat(i, 2, 1, 1);
            tick();
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_inner", 32'(inner), 32'd0);
        check("arst_mid",   32'(mid),   32'd0);
        check("arst_beat",  32'(beat),  32'd0);
        check("arst_last",  32'(last),  32'd0);
        #1;
        rst_ni = 1'b1;
        tick();
        tick();
        check("arst_stay_idle", 32'(busy),  32'd0);
        check("arst_no_valid",  32'(valid), 32'd0);
        do_start(1, 1, 1);
        finish_pass(0, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
